// File: rtl/capture_ctrl.sv
// Purpose : trigger/capture sequencer feeding the write side of the sample FIFO.
// Latency : registered outputs; w_inc_o/w_data_o appear one cycle after the accepted sample.
// Backpr. : fifo_full_i drops the candidate sample (sticky overflow_o); the record length is unchanged.
//
// Ports: clk_i/rst_i (async active-low), arm_i/abort_i control, sample_i/sample_valid_i stream,
//        trig_level_i threshold, capture_len_i record length (latched on arm), fifo_full_i,
//        w_inc_o/w_data_o FIFO write, armed_o/busy_o/done_o status, overflow_o, count_o.
// Optional: define CAPTURE_DECIM_EN to add decim_i[7:0] (write every (decim_i+1)-th sample).
module capture_ctrl #(
    parameter int DATA_SIZE = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    input  logic [CNT_SIZE-1:0]  capture_len_i,
    input  logic                 fifo_full_i,
`ifdef CAPTURE_DECIM_EN
    input  logic [7:0]           decim_i,
`endif
    output logic                 w_inc_o,
    output logic [DATA_SIZE-1:0] w_data_o,
    output logic                 armed_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [CNT_SIZE-1:0]  count_o
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_SIZE-1:0]   len_q;
    logic [CNT_SIZE-1:0]   count_q, count_nxt;
    logic                  overflow_q;
    logic [DATA_SIZE-1:0]  prev_q;
    logic                  prev_vld_q;
    logic                  w_inc_q;
    logic [DATA_SIZE-1:0]  w_data_q;
    logic                  trig;
    logic                  arm_ok;
    logic                  wr;
    logic                  drop;
    logic                  decim_hit;
    logic                  phase_rst;
    logic                  phase_adv;

`ifdef CAPTURE_DECIM_EN
    logic [7:0]            decim_q;
    logic [7:0]            phase_q;
    // phase counts valid samples since the last candidate; never exceeds decim_q
    assign decim_hit = (phase_q == decim_q);
`else
    assign decim_hit = 1'b1;
`endif

    // Rising crossing: previous valid sample below the level, current one at/above it
    assign trig = sample_valid_i & prev_vld_q & (prev_q < trig_level_i) & (sample_i >= trig_level_i);

    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        arm_ok    = 1'b0;
        wr        = 1'b0;
        drop      = 1'b0;
        phase_rst = 1'b0;
        phase_adv = 1'b0;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_i && (capture_len_i != '0)) begin
                        arm_ok    = 1'b1;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        // trigger sample is always a candidate
                        phase_rst = 1'b1;
                        wr        = ~fifo_full_i;
                        drop      = fifo_full_i;
                        count_nxt = CNT_SIZE'(wr);
                        state_nxt = (count_nxt == len_q) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sample_valid_i) begin
                        if (decim_hit) begin
                            phase_rst = 1'b1;
                            wr        = ~fifo_full_i;
                            drop      = fifo_full_i;
                            // count_q < len_q here, so the increment cannot wrap
                            count_nxt = count_q + CNT_SIZE'(wr);
                        end else begin
                            phase_adv = 1'b1;
                        end
                    end
                    if (count_nxt == len_q) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            len_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            w_inc_q    <= 1'b0;
            w_data_q   <= '0;
        end else begin
            state   <= state_nxt;
            w_inc_q <= wr;
            if (wr) begin
                w_data_q <= sample_i;
            end
            if (arm_ok) begin
                len_q      <= capture_len_i;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                count_q <= count_nxt;
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
            if (sample_valid_i) begin
                prev_q     <= sample_i;
                prev_vld_q <= 1'b1;
            end
            // arming discards history so the first sample after arm cannot trigger
            if (arm_ok) begin
                prev_vld_q <= 1'b0;
            end
        end
    end

`ifdef CAPTURE_DECIM_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            decim_q <= '0;
            phase_q <= '0;
        end else begin
            if (arm_ok) begin
                decim_q <= decim_i;
                phase_q <= '0;
            end else if (phase_rst) begin
                phase_q <= '0;
            end else if (phase_adv) begin
                phase_q <= phase_q + 8'd1;
            end
        end
    end
`endif

    assign w_inc_o    = w_inc_q;
    assign w_data_o   = w_data_q;
    assign armed_o    = (state == ARMED);
    assign busy_o     = (state == ARMED) || (state == CAPTURE);
    assign done_o     = (state == DONE);
    assign overflow_o = overflow_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [DW-1:0] sample_i = '0;
    logic          sample_valid_i = 1'b0;
    logic [DW-1:0] trig_level_i = 4'd8;
    logic [CW-1:0] capture_len_i = '0;
    logic          fifo_full_i = 1'b0;
    logic [7:0]    decim_i = '0;
    logic          w_inc_o;
    logic [DW-1:0] w_data_o;
    logic          armed_o, busy_o, done_o, overflow_o;
    logic [CW-1:0] count_o;

    capture_ctrl #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .trig_level_i(trig_level_i), .capture_len_i(capture_len_i),
        .fifo_full_i(fifo_full_i),
`ifdef CAPTURE_DECIM_EN
        .decim_i(decim_i),
`endif
        .w_inc_o(w_inc_o), .w_data_o(w_data_o), .armed_o(armed_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;
    int wlog[$];
    int n_done = 0;

    // Reference model: record progress expressed as counts and sample indices
    bit m_wait, m_rec, m_fin, m_wr, m_ovf, m_pv;
    int m_wdat, m_len, m_cnt, m_k, m_dec, m_prev;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wait = 0; m_rec = 0; m_fin = 0; m_wr = 0; m_ovf = 0; m_pv = 0;
        m_wdat = 0; m_len = 0; m_cnt = 0; m_k = 0; m_dec = 0; m_prev = 0;
    endtask

    task automatic take();
        if (fifo_full_i) m_ovf = 1;
        else begin
            m_wr = 1;
            m_wdat = int'(sample_i);
            m_cnt++;
        end
        if (m_cnt == m_len) begin
            m_rec = 0;
            m_fin = 1;
        end
    endtask

    task automatic model_step();
        bit trig, arming;
        int s, lvl;
        s = int'(sample_i);
        lvl = int'(trig_level_i);
        arming = 0;
        m_wr = 0;
        trig = sample_valid_i && m_pv && (m_prev < lvl) && (s >= lvl);
        if (abort_i) begin
            m_wait = 0; m_rec = 0; m_fin = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (!m_wait && !m_rec) begin
            if (arm_i && capture_len_i != 0) begin
                m_wait = 1; m_len = int'(capture_len_i); m_cnt = 0; m_ovf = 0; arming = 1;
`ifdef CAPTURE_DECIM_EN
                m_dec = int'(decim_i);
`else
                m_dec = 0;
`endif
            end
        end else if (m_wait) begin
            if (trig) begin
                m_wait = 0; m_rec = 1; m_k = 0;
                take();
            end
        end else if (sample_valid_i) begin
            m_k++;
            if (m_k % (m_dec + 1) == 0) take();
        end
        if (sample_valid_i) begin
            m_prev = s;
            m_pv = 1;
        end
        if (arming) m_pv = 0;
    endtask

    task automatic check_model();
        if (w_inc_o) wlog.push_back(int'(w_data_o));
        if (done_o) n_done++;
        chk("w_inc", int'(w_inc_o), int'(m_wr));
        if (m_wr) chk("w_data", int'(w_data_o), m_wdat);
        chk("armed", int'(armed_o), int'(m_wait));
        chk("busy", int'(busy_o), int'(m_wait | m_rec));
        chk("done", int'(done_o), int'(m_fin));
        chk("overflow", int'(overflow_o), int'(m_ovf));
        chk("count", int'(count_o), m_cnt);
    endtask

    // Apply inputs just after a falling edge, clock once, check at the next falling edge
    task automatic drv(input bit a, input bit ab, input bit v, input int s, input bit f);
        arm_i = a; abort_i = ab; sample_valid_i = v; sample_i = DW'(s); fifo_full_i = f;
        model_step();
        @(negedge clk_i);
        check_model();
    endtask

    task automatic chk_log(input string nm, input int exp[]);
        chk({nm, "_len"}, wlog.size(), exp.size());
        foreach (exp[i]) begin
            if (i < wlog.size()) chk(nm, wlog[i], exp[i]);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_winc"}, int'(w_inc_o), 0);
        chk({nm, "_busy"}, int'(busy_o), 0);
        chk({nm, "_armed"}, int'(armed_o), 0);
        chk({nm, "_done"}, int'(done_o), 0);
        chk({nm, "_ovf"}, int'(overflow_o), 0);
        chk({nm, "_cnt"}, int'(count_o), 0);
    endtask

    task automatic clear_log();
        wlog.delete();
        n_done = 0;
    endtask

    initial begin
        model_reset();
        // 1: reset and idle
        repeat (2) @(negedge clk_i);
        chk_zero("rst");
        rst_i = 1'b1;
        drv(0, 0, 0, 0, 0);
        chk_zero("idle");

        // 2: ramp capture, len 4
        clear_log();
        trig_level_i = 4'd8; capture_len_i = 8'd4;
        drv(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drv(0, 0, 1, i, 0);
        chk_log("ramp_wr", '{8, 9, 10, 11});
        chk("ramp_done_n", n_done, 1);
        chk("ramp_cnt", int'(count_o), 4);
        chk("ramp_ovf", int'(overflow_o), 0);

        // 3: already above level on arm; trigger only on a real crossing
        clear_log();
        capture_len_i = 8'd2;
        drv(1, 0, 1, 12, 0);
        drv(0, 0, 1, 12, 0);
        drv(0, 0, 1, 12, 0);
        drv(0, 0, 1, 3, 0);
        chk("hi_armed", int'(armed_o), 1);
        drv(0, 0, 1, 9, 0);
        chk("hi_trig_armed", int'(armed_o), 0);
        drv(0, 0, 1, 10, 0);
        drv(0, 0, 0, 0, 0);
        chk_log("hi_wr", '{9, 10});

        // 4: full on 2nd and 3rd capture samples
        clear_log();
        capture_len_i = 8'd6;
        drv(1, 0, 0, 0, 0);
        drv(0, 0, 1, 7, 0);
        drv(0, 0, 1, 8, 0);
        drv(0, 0, 1, 9, 1);
        drv(0, 0, 1, 10, 1);
        for (int i = 11; i < 15; i++) drv(0, 0, 1, i, 0);
        chk("full_nodone_yet", n_done, 0);
        drv(0, 0, 1, 15, 0);
        chk("full_done", int'(done_o), 1);
        drv(0, 0, 0, 0, 0);
        chk_log("full_wr", '{8, 11, 12, 13, 14, 15});
        chk("full_ovf", int'(overflow_o), 1);
        chk("full_cnt", int'(count_o), 6);

        // 5: abort at count 2, then re-arm
        clear_log();
        drv(1, 0, 0, 0, 0);
        drv(0, 0, 1, 7, 0);
        drv(0, 0, 1, 8, 0);
        drv(0, 0, 1, 9, 0);
        drv(0, 1, 1, 10, 0);
        chk("abort_busy", int'(busy_o), 0);
        for (int i = 11; i < 15; i++) drv(0, 0, 1, i, 0);
        chk_log("abort_wr", '{8, 9});
        chk("abort_done_n", n_done, 0);
        chk("abort_cnt", int'(count_o), 2);
        capture_len_i = 8'd3;
        drv(1, 0, 0, 0, 0);
        chk("rearm_cnt", int'(count_o), 0);
        chk("rearm_armed", int'(armed_o), 1);

        // reset mid-capture
        drv(0, 0, 1, 2, 0);
        drv(0, 0, 1, 9, 0);
        rst_i = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drv(0, 0, 1, 5, 0);

`ifdef CAPTURE_DECIM_EN
        // 6: decimation by 3
        clear_log();
        decim_i = 8'd2; capture_len_i = 8'd3;
        drv(1, 0, 0, 0, 0);
        for (int i = 7; i < 16; i++) drv(0, 0, 1, i, 0);
        chk_log("decim_wr", '{8, 11, 14});
`endif

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) trig_level_i = DW'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) capture_len_i = CW'($urandom_range(0, 6));
`ifdef CAPTURE_DECIM_EN
            if ($urandom_range(0, 15) == 0) decim_i = 8'($urandom_range(0, 2));
`endif
            drv($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
                $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
